sram_word_bridge: RTL

//  Initiator side of the byte-wide BSRAM port. Converts one 32-bit word request
//  (valid/ready, byte enables) into four sequential byte accesses on the 8-bit
//  clk_en/wrt_en/addr/data SRAM interface, then returns a one-cycle response.

---
 rtl/sram_pkg.sv | 18 +
 rtl/sram_word_bridge.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the byte-wide BSRAM port: bridge FSM states and
// word/beat geometry used by the word bridge and the memory map.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } state_e;

    // One 32-bit word is moved as four byte beats.
    localparam int unsigned BEATS  = 4;
    localparam int unsigned BEAT_W = 2;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

endpackage

// File: rtl/sram_word_bridge.sv
// sram_word_bridge: initiator side of the byte-wide BSRAM port.
// Turns one 32-bit word request into four byte beats on the 8-bit SRAM port,
// then returns a one-cycle response (write: 5 cycles after accept, read: 6).
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   req_valid_i/ready_o  request handshake; ready only while idle
//   req_we_i             1 = write, 0 = read
//   req_addr_i           byte address, [1:0] ignored (word aligned)
//   req_wdata_i/be_i     write data (byte0 = [7:0]) and byte enables
//   rsp_valid_o          one-cycle completion pulse
//   rsp_rdata_o          read data, held until the next read response
//   mem_clk_en_o/wrt_en_o/addr_o/data_o  SRAM control, address, write data
//   mem_data_i           SRAM read data, one cycle after a read beat
module sram_word_bridge
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [3:0]            req_be_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  mem_clk_en_o,
    output logic                  mem_wrt_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [7:0]            mem_data_o,
    input  logic [7:0]            mem_data_i
);

    localparam int unsigned BASE_W = ADDR_WIDTH - BEAT_W;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BEAT_W-1:0]   prev_beat_c;
    logic                we_q, we_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic [23:0]         shadow_q, shadow_d;
    logic [31:0]         rdata_d;
    logic                accept_c;

    logic                req_ready_d;
    logic                rsp_valid_d;
    logic                mem_clk_en_d;
    logic                mem_wrt_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [7:0]          mem_data_d;

    // Word alignment: the byte-offset bits of the request address carry no meaning.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr_i[BEAT_W-1:0];

    assign accept_c    = (state_q == IDLE) && req_valid_i;
    assign prev_beat_c = beat_q - BEAT_W'(1);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = ACCESS;
            ACCESS:  if (beat_q == LAST_BEAT) state_d = we_q ? RESP : DRAIN;
            DRAIN:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; port signals are computed for the
    // upcoming cycle so the registered SRAM outputs line up with the beat.
    always_comb begin
        beat_d       = beat_q;
        we_d         = we_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        shadow_d     = shadow_q;
        rdata_d      = rsp_rdata_o;
        mem_clk_en_d = 1'b0;
        mem_wrt_en_d = 1'b0;
        mem_addr_d   = '0;
        mem_data_d   = '0;
        rsp_valid_d  = (state_d == RESP);
        req_ready_d  = (state_d == IDLE);

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    we_d    = req_we_i;
                    base_d  = req_addr_i[ADDR_WIDTH-1:BEAT_W];
                    wdata_d = req_wdata_i;
                    be_d    = req_be_i;
                    beat_d  = '0;
                end
            end
            ACCESS: begin
                beat_d = beat_q + BEAT_W'(1);
                // Read data lags its beat by one cycle: capture the previous lane.
                if (!we_q && (beat_q != '0)) begin
                    shadow_d[{prev_beat_c, 3'b000} +: 8] = mem_data_i;
                end
            end
            DRAIN: begin
                // Last lane arrives now; assemble the response word directly.
                rdata_d = {mem_data_i, shadow_q};
            end
            default: ;
        endcase

        if (state_d == ACCESS) begin
            mem_addr_d = {base_d, beat_d};
            if (we_d) begin
                // Disabled lanes leave the port idle but still take their cycle.
                mem_clk_en_d = be_d[beat_d];
                mem_wrt_en_d = be_d[beat_d];
                mem_data_d   = wdata_d[{beat_d, 3'b000} +: 8];
            end else begin
                mem_clk_en_d = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_q       <= '0;
            we_q         <= 1'b0;
            base_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            shadow_q     <= '0;
            rsp_rdata_o  <= '0;
            rsp_valid_o  <= 1'b0;
            req_ready_o  <= 1'b1;
            mem_clk_en_o <= 1'b0;
            mem_wrt_en_o <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            beat_q       <= beat_d;
            we_q         <= we_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            shadow_q     <= shadow_d;
            rsp_rdata_o  <= rdata_d;
            rsp_valid_o  <= rsp_valid_d;
            req_ready_o  <= req_ready_d;
            mem_clk_en_o <= mem_clk_en_d;
            mem_wrt_en_o <= mem_wrt_en_d;
            mem_addr_o   <= mem_addr_d;
            mem_data_o   <= mem_data_d;
        end
    end

endmodule
